// File: rtl/control_pkg.sv
// control_pkg: opcode, ALU-op, mux-select and state encodings shared by the
// multicycle control FSM and the downstream ALU-control decoder.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

endpackage

// File: rtl/retire_counter.sv
// retire_counter: free-running wrap-around counter with enable and
// synchronous clear.
module retire_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk)
        count_q <= rst ? '0 : en_i ? count_q + 1'b1 : count_q;

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath;
// outputs are decoded combinationally from the state and forced low in reset.
module multicycle_control
    import control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e state_q, state_d;
    logic   retire;
    logic   unused_zero;

    // The branch decision on zero is taken in the datapath via pc_write_cond.
    assign unused_zero = zero;

    always_ff @(posedge clk)
        state_q <= rst ? S_FETCH : state_d;

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        retire        = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_4;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        default:      illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                    state_d   = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    retire    = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state = rst ? 4'd0 : state_q;

    retire_counter #(.W(CNT_W)) u_retire (
        .clk    (clk),
        .rst    (rst),
        .en_i   (retire),
        .count_o(retired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction streams checked
// against an instruction-level reference model of the control sequence.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] retired;
    logic        n_pw, n_pwc, n_iod, n_mr, n_mw, n_irw, n_m2r, n_rd, n_rw, n_sa, n_ill;
    logic [1:0]  n_sb, n_ao, n_ps;
    logic [3:0]  n_state;
    logic [3:0]  retired4;
    logic [15:0] ctl;

    int total = 0;
    int bad = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state), .retired(retired)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(n_pw), .pc_write_cond(n_pwc), .i_or_d(n_iod),
        .mem_read(n_mr), .mem_write(n_mw), .ir_write(n_irw),
        .mem_to_reg(n_m2r), .reg_dst(n_rd), .reg_write(n_rw),
        .alu_src_a(n_sa), .alu_src_b(n_sb), .alu_op(n_ao),
        .pc_source(n_ps), .illegal_op(n_ill), .state(n_state), .retired(retired4)
    );

    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control word each state must present, written straight from the state table.
    function automatic logic [15:0] exp_ctl(input int s, input logic mr);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps};
    endfunction

    task automatic step(input string tag, input int s, input logic mr, input logic ill);
        mem_ready = mr;
        zero = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "/state"}, 32'(state), 32'(s));
        chk({tag, "/ctl"}, 32'(ctl), 32'(exp_ctl(s, mr)));
        chk({tag, "/illegal"}, 32'(illegal_op), 32'(ill));
        chk({tag, "/retired"}, retired, 32'(cnt));
        chk({tag, "/retired4"}, 32'(retired4), 32'(cnt % 16));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst/state", 32'(state), 0);
            chk("rst/ctl", 32'(ctl), 0);
            chk("rst/illegal", 32'(illegal_op), 0);
            @(posedge clk);
            @(negedge clk);
            chk("rst/retired", retired, 0);
        end
        rst = 1'b0;
        cnt = 0;
    endtask

    // One instruction: fs fetch stalls, ms memory stalls, sequence from the opcode rules.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        logic ill;
        ill = !(op inside {RT, LW, SW, BQ, JJ, AI});
        for (int i = 0; i <= fs; i++) begin
            opcode = 6'($urandom);
            step("fetch", 0, i == fs, 0);
        end
        opcode = op;
        step("decode", 1, 1'($urandom), ill);
        case (op)
            RT: begin step("exec", 6, 1'($urandom), 0); step("rwb", 7, 1'($urandom), 0); end
            LW: begin
                step("maddr", 2, 1'($urandom), 0);
                for (int i = 0; i <= ms; i++) step("memrd", 3, i == ms, 0);
                step("memwb", 4, 1'($urandom), 0);
            end
            SW: begin
                step("maddr", 2, 1'($urandom), 0);
                for (int i = 0; i <= ms; i++) step("memwr", 5, i == ms, 0);
            end
            BQ: step("branch", 8, 1'($urandom), 0);
            JJ: step("jump", 9, 1'($urandom), 0);
            AI: begin step("addiex", 10, 1'($urandom), 0); step("addiwb", 11, 1'($urandom), 0); end
            default: ;
        endcase
        if (!ill) cnt++;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{RT, LW, SW, BQ, JJ, AI};
        @(negedge clk);
        do_reset(2);
        run_instr(RT, 0, 0);
        run_instr(LW, 0, 3);
        zero = 1'b1;
        run_instr(BQ, 0, 0);
        run_instr(BQ, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(AI, 2, 0);
        run_instr(SW, 1, 2);
        run_instr(JJ, 0, 0);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (op inside {RT, LW, SW, BQ, JJ, AI});
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, $urandom_range(0, 3));
        end
        do_reset(1);
        for (int n = 0; n < 16; n++) run_instr(JJ, 0, 0);
        #1;
        chk("wrap/retired4", 32'(retired4), 0);
        chk("wrap/retired", retired, 16);
        @(negedge clk);
        run_instr(RT, 0, 0);
        for (int i = 0; i < 2; i++) begin
            opcode = 6'($urandom);
            step("fetch", 0, i == 1, 0);
        end
        opcode = SW;
        step("decode", 1, 1'b1, 0);
        step("maddr", 2, 1'b1, 0);
        step("memwr", 5, 1'b0, 0);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("midrst/mem_write", 32'(mem_write), 0);
        chk("midrst/ctl", 32'(ctl), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        run_instr(LW, 0, 0);
        run_instr(RT, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
